// File: rtl/port_rr_drain.sv
// ---------------------------------------------------------------------------
// port_rr_drain
//   Drains a bank of NUM_PORTS port FIFOs into a single valid/ready stream.
//   The ports are served round-robin, and a grant lasts for at most BURST_LEN
//   reads. Each word carries the id of the port it came from. A 2-entry skid
//   buffer lets the block keep reading at 1 word/cycle while out_ready is high.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   port_rdy   [NUM_PORTS]          port i FIFO holds at least one word
//   port_rd    [NUM_PORTS]          one-hot read strobe to port i
//   port_out   [NUM_PORTS*W_WIDTH]  port i data at [i*W_WIDTH +: W_WIDTH],
//                                   valid the cycle after its strobe
//   out_data   [W_WIDTH]            head word of the output buffer
//   out_id     [ID_W]               source port of out_data
//   out_valid                       output buffer non-empty
//   out_ready                       downstream accepts when out_valid && out_ready
//
// FSM states
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | arbitration bubble: pick the first ready port from r_rr_ptr up
//   S_BURST  | read the granted port while it is ready, the burst is not used
//            | up and the skid buffer has room
// ---------------------------------------------------------------------------
module port_rr_drain #(
   parameter int NUM_PORTS = 4,
   parameter int W_WIDTH   = 8,
   parameter int BURST_LEN = 4,
   parameter int ID_W      = $clog2(NUM_PORTS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_PORTS-1:0]          port_rdy,
   output logic [NUM_PORTS-1:0]          port_rd,
   input  logic [NUM_PORTS*W_WIDTH-1:0]  port_out,
   output logic [W_WIDTH-1:0]            out_data,
   output logic [ID_W-1:0]               out_id,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int BC_W = $clog2(BURST_LEN + 1);
   localparam logic [BC_W-1:0] BURST_MAX  = BC_W'(BURST_LEN);
   localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN - 1);
   localparam logic [ID_W:0]   PORTS_EXT  = (ID_W + 1)'(NUM_PORTS);
   localparam logic [ID_W-1:0] PORT_LAST  = ID_W'(NUM_PORTS - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_rr_ptr;
   logic [ID_W-1:0]     w_rr_ptr_nxt;
   logic [ID_W-1:0]     r_grant;
   logic [ID_W-1:0]     w_grant_nxt;
   logic [BC_W-1:0]     r_burst_cnt;
   logic [BC_W-1:0]     w_burst_cnt_nxt;

   // word strobed last cycle, captured from its port this cycle
   logic                r_inflight;
   logic [ID_W-1:0]     r_inflight_id;

   // skid buffer, slot 0 is the head
   logic [W_WIDTH-1:0]  r_buf_data [2];
   logic [ID_W-1:0]     r_buf_id   [2];
   logic [1:0]          r_cnt;

   logic [2*NUM_PORTS-1:0] w_rdy_rot2;
   logic [NUM_PORTS-1:0]   w_rdy_rot;
   logic [ID_W-1:0]        w_off;
   logic [ID_W:0]          w_sum;
   logic [ID_W-1:0]        w_pick;
   logic                   w_any_rdy;
   logic [ID_W-1:0]        w_ptr_after;

   logic                w_pop;
   logic                w_push;
   logic                w_issue;
   logic                w_space;
   logic                w_grant_rdy;
   logic [1:0]          w_occ;
   logic [1:0]          w_wr_pos;
   logic [W_WIDTH-1:0]  w_cap_data;

   // ------------------------------------------------------------------
   // Round-robin pick: rotate the ready vector so r_rr_ptr sits at bit 0,
   // find the lowest set bit, then rotate the offset back.
   // ------------------------------------------------------------------
   assign w_any_rdy  = |port_rdy;
   assign w_rdy_rot2 = {port_rdy, port_rdy} >> r_rr_ptr;
   assign w_rdy_rot  = w_rdy_rot2[NUM_PORTS-1:0];

   always_comb begin
      w_off = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (w_rdy_rot[k]) begin
            w_off = ID_W'(k);
         end
      end
   end

   assign w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
   assign w_pick = (w_sum >= PORTS_EXT) ? ID_W'(w_sum - PORTS_EXT) : ID_W'(w_sum);

   assign w_ptr_after = (r_grant == PORT_LAST) ? '0 : r_grant + 1'b1;

   // ------------------------------------------------------------------
   // Space check: a read is allowed when the word can land in the buffer
   // the cycle after next, counting the word already in flight. A full
   // pipeline may still read if the head leaves this cycle.
   // ------------------------------------------------------------------
   assign w_pop       = (r_cnt != 2'd0) && out_ready;
   assign w_push      = r_inflight;
   assign w_occ       = r_cnt + {1'b0, r_inflight};
   assign w_space     = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);
   assign w_grant_rdy = port_rdy[r_grant];

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_grant     <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_grant     <= w_grant_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_grant_nxt     = r_grant;
      w_burst_cnt_nxt = r_burst_cnt;
      w_issue         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_rdy) begin
               w_grant_nxt     = w_pick;
               w_burst_cnt_nxt = '0;
               w_state_nxt     = S_BURST;
            end
         end
         S_BURST: begin
            if (!w_grant_rdy) begin
               w_state_nxt  = S_IDLE;
               w_rr_ptr_nxt = w_ptr_after;
            end else if ((r_burst_cnt < BURST_MAX) && w_space) begin
               w_issue         = 1'b1;
               w_burst_cnt_nxt = r_burst_cnt + 1'b1;
               if (r_burst_cnt == BURST_LAST) begin
                  w_state_nxt  = S_IDLE;
                  w_rr_ptr_nxt = w_ptr_after;
               end
            end
            // no space: hold the grant without reading
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      port_rd = '0;
      if (w_issue) begin
         port_rd[r_grant] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Capture of the strobed word
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight    <= 1'b0;
         r_inflight_id <= '0;
      end else begin
         r_inflight    <= w_issue;
         r_inflight_id <= r_grant;
      end
   end

   always_comb begin
      w_cap_data = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (r_inflight_id == ID_W'(i)) begin
            w_cap_data = port_out[i*W_WIDTH +: W_WIDTH];
         end
      end
   end

   // ------------------------------------------------------------------
   // Skid buffer. On a pop, slot 1 shifts into slot 0. A push writes the
   // slot just past the entries that remain after the pop. When both land
   // on slot 0, the push is written last and wins.
   // ------------------------------------------------------------------
   assign w_wr_pos = r_cnt - {1'b0, w_pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf_data[0] <= '0;
         r_buf_data[1] <= '0;
         r_buf_id[0]   <= '0;
         r_buf_id[1]   <= '0;
         r_cnt         <= 2'd0;
      end else begin
         if (w_pop) begin
            r_buf_data[0] <= r_buf_data[1];
            r_buf_id[0]   <= r_buf_id[1];
         end
         if (w_push) begin
            if (w_wr_pos[0]) begin
               r_buf_data[1] <= w_cap_data;
               r_buf_id[1]   <= r_inflight_id;
            end else begin
               r_buf_data[0] <= w_cap_data;
               r_buf_id[0]   <= r_inflight_id;
            end
         end
         r_cnt <= r_cnt - {1'b0, w_pop} + {1'b0, w_push};
      end
   end

   assign out_valid = (r_cnt != 2'd0);
   assign out_data  = r_buf_data[0];
   assign out_id    = r_buf_id[0];

endmodule

// File: tb/tb_port_rr_drain.sv
// ---------------------------------------------------------------------------
// tb_port_rr_drain
//   Directed scenarios followed by a randomized run for port_rr_drain.
//   Each port is modelled as a FIFO queue. The scoreboard holds, for each
//   port, the words still owed to the output, in the order they were loaded.
//   Grant order and burst lengths are derived from the log of observed reads.
// ---------------------------------------------------------------------------
module tb_port_rr_drain;

   localparam int NP = 4;
   localparam int W  = 8;
   localparam int BL = 4;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NP-1:0]     port_rdy;
   logic [NP-1:0]     port_rd;
   logic [NP*W-1:0]   port_out;
   logic [W-1:0]      out_data;
   logic [IW-1:0]     out_id;
   logic              out_valid;
   logic              out_ready;

   always #5 clk = ~clk;

   port_rr_drain #(
      .NUM_PORTS (NP),
      .W_WIDTH   (W),
      .BURST_LEN (BL),
      .ID_W      (IW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .port_rdy  (port_rdy),
      .port_rd   (port_rd),
      .port_out  (port_out),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   logic [W-1:0]  pq  [NP][$];   // contents of each port FIFO
   logic [W-1:0]  exq [NP][$];   // words owed to the output, per port
   int            n_checks = 0;
   int            n_err    = 0;
   int            cyc      = 0;
   int            outstanding = 0;   // words read from ports but not yet accepted
   int            rd_log[$];
   int            rd_cyc[$];
   int            out_cyc[$];
   int            runs_p[$];
   int            runs_n[$];
   logic [NP-1:0] rdy_mask;
   bit            prev_hold;
   logic [W-1:0]  prev_data;
   logic [IW-1:0] prev_id;
   int            seq [NP];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic update_rdy();
      for (int i = 0; i < NP; i++) begin
         port_rdy[i] = rdy_mask[i] && (pq[i].size() != 0);
      end
   endtask

   task automatic load(input int p, input logic [W-1:0] w);
      pq[p].push_back(w);
      exq[p].push_back(w);
   endtask

   function automatic bit all_empty();
      bit e;
      e = (outstanding == 0);
      for (int i = 0; i < NP; i++) begin
         if (exq[i].size() != 0) e = 1'b0;
      end
      return e;
   endfunction

   task automatic clear_logs();
      rd_log.delete();
      rd_cyc.delete();
      out_cyc.delete();
   endtask

   task automatic build_runs();
      runs_p.delete();
      runs_n.delete();
      foreach (rd_log[i]) begin
         if (runs_p.size() == 0 || runs_p[runs_p.size()-1] != rd_log[i]) begin
            runs_p.push_back(rd_log[i]);
            runs_n.push_back(1);
         end else begin
            runs_n[runs_n.size()-1] = runs_n[runs_n.size()-1] + 1;
         end
      end
   endtask

   // One clock: observe at the falling edge, then update the port model
   // just after the rising edge. Returns at posedge+1.
   task automatic step();
      int rd;
      bit pop;
      int id;
      @(negedge clk);
      cyc++;
      check("rd_onehot", 32'($onehot0(port_rd)), 32'd1);
      check("rd_to_ready", 32'(port_rd & ~port_rdy), 32'd0);
      if (prev_hold) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_data", 32'(out_data), 32'(prev_data));
         check("hold_id", 32'(out_id), 32'(prev_id));
      end
      rd = -1;
      for (int i = 0; i < NP; i++) begin
         if (port_rd[i]) rd = i;
      end
      pop = out_valid && out_ready;
      if (pop) begin
         id = int'(out_id);
         check("out_expected", 32'(exq[id].size() != 0), 32'd1);
         if (exq[id].size() != 0) begin
            check($sformatf("out_data_p%0d", id), 32'(out_data), 32'(exq[id].pop_front()));
         end
         out_cyc.push_back(cyc);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_id   = out_id;
      @(posedge clk);
      #1;
      if (rd >= 0) begin
         rd_log.push_back(rd);
         rd_cyc.push_back(cyc);
         outstanding++;
         if (pq[rd].size() != 0) port_out[rd*W +: W] = pq[rd].pop_front();
      end
      if (pop) outstanding--;
      check("occupancy", 32'(outstanding <= 2), 32'd1);
      update_rdy();
   endtask

   task automatic drain(input int budget, input string tag);
      int n;
      n = 0;
      rdy_mask  = '1;
      out_ready = 1'b1;
      update_rdy();
      while (n < budget && !all_empty()) begin
         step();
         n++;
      end
      check({tag, "_drained"}, 32'(all_empty()), 32'd1);
   endtask

   task automatic check_order(input string tag, input int exp_ports[$]);
      check({tag, "_nreads"}, 32'(rd_log.size()), 32'(exp_ports.size()));
      if (rd_log.size() == exp_ports.size()) begin
         foreach (exp_ports[i]) begin
            check($sformatf("%s_port%0d", tag, i), 32'(rd_log[i]), 32'(exp_ports[i]));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      rdy_mask  = '0;
      port_rdy  = '0;
      port_out  = '0;
      prev_hold = 1'b0;
      for (int i = 0; i < NP; i++) seq[i] = 0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_port_rd", 32'(port_rd), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_id", 32'(out_id), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // port 2 with three words: consecutive reads and back-to-back output
      clear_logs();
      rdy_mask  = '1;
      out_ready = 1'b1;
      load(2, 8'hA1);
      load(2, 8'hA2);
      load(2, 8'hA3);
      update_rdy();
      drain(40, "t1");
      check_order("t1", '{2, 2, 2});
      if (rd_cyc.size() == 3) check("t1_rd_consec", 32'(rd_cyc[2] - rd_cyc[0]), 32'd2);
      if (out_cyc.size() == 3) check("t1_out_b2b", 32'(out_cyc[2] - out_cyc[0]), 32'd2);

      // pointer now 3: ports 0,1,3 ready -> 3,0,1
      clear_logs();
      load(0, 8'h10);
      load(1, 8'h11);
      load(3, 8'h13);
      update_rdy();
      drain(40, "t_ptr3");
      check_order("t_ptr3", '{3, 0, 1});

      // grant port 0 alone so the pointer moves to 1
      clear_logs();
      load(0, 8'h20);
      update_rdy();
      drain(30, "t_p0");
      check_order("t_p0", '{0});

      // pointer 1, ports 0 and 3 ready -> 3 first, then 0
      clear_logs();
      load(0, 8'h30);
      load(3, 8'h33);
      update_rdy();
      drain(40, "t4");
      check_order("t4", '{3, 0});

      // stall: port 1 with five words, out_ready low for 10 cycles
      clear_logs();
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) load(1, 8'(8'h41 + j));
      update_rdy();
      repeat (10) step();
      check("t3_stall_reads", 32'(rd_log.size()), 32'd2);
      check("t3_rd_quiet", 32'(port_rd), 32'd0);
      check("t3_head_valid", 32'(out_valid), 32'd1);
      check("t3_head_data", 32'(out_data), 32'h41);
      check("t3_head_id", 32'(out_id), 32'd1);
      drain(80, "t3");
      check_order("t3", '{1, 1, 1, 1, 1});
      if (rd_cyc.size() == 5) check("t3_regrant_gap", 32'(rd_cyc[4] - rd_cyc[3] >= 2), 32'd1);

      // reset mid-burst with the buffer full
      clear_logs();
      out_ready = 1'b0;
      for (int j = 0; j < 5; j++) load(2, 8'(8'h51 + j));
      update_rdy();
      repeat (6) step();
      check("rst_mid_full", 32'(outstanding), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_port_rd", 32'(port_rd), 32'd0);
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_data", 32'(out_data), 32'd0);
      check("rst_mid_id", 32'(out_id), 32'd0);
      for (int i = 0; i < NP; i++) begin
         pq[i].delete();
         exq[i].delete();
      end
      outstanding = 0;
      prev_hold   = 1'b0;
      rdy_mask    = '0;
      port_out    = '0;
      update_rdy();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // all ports with six words each, starting from pointer 0
      clear_logs();
      rdy_mask  = '1;
      out_ready = 1'b1;
      for (int p = 0; p < NP; p++) begin
         for (int j = 0; j < 6; j++) load(p, 8'(p * 16 + j));
      end
      update_rdy();
      drain(200, "t2");
      check("t2_nreads", 32'(rd_log.size()), 32'd24);
      build_runs();
      check("t2_nruns", 32'(runs_p.size()), 32'd8);
      if (runs_p.size() == 8) begin
         for (int r = 0; r < 8; r++) begin
            check($sformatf("t2_run%0d_port", r), 32'(runs_p[r]), 32'(r % NP));
            check($sformatf("t2_run%0d_len", r), 32'(runs_n[r]), (r < NP) ? 32'd4 : 32'd2);
         end
      end

      // randomized port readiness and downstream backpressure
      clear_logs();
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 2) == 0) begin
            int p;
            p = int'($urandom_range(0, NP - 1));
            if (pq[p].size() < 6) begin
               load(p, 8'(seq[p]));
               seq[p]++;
            end
         end
         for (int i = 0; i < NP; i++) rdy_mask[i] = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         update_rdy();
         step();
      end
      drain(400, "rand");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
